// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program-memory refill controller.
package prog_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LINE_W = 8;
  localparam int IDX_W  = $clog2(LINE_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEMAND,
    ST_PREFETCH,
    ST_DRAIN
  } state_t;

  // Clears the word-index bits, giving the base address of the enclosing line.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
  endfunction

endpackage

// File: rtl/prog_mem_refill_ctrl_line_tag.sv
// Base/valid tag for one cache bank with a combinational line-match output.
module line_tag
  import prog_mem_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_valid,
  output logic              o_match
);

  logic [ADDR_W-1:0] r_base;
  logic              r_valid;

  // Tag update: a load replaces the base and invalidates, and a clear beats a set.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_base  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_base  <= i_base;
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_set) begin
      r_valid <= 1'b1;
    end
  end

  assign o_base  = r_base;
  assign o_valid = r_valid;
  assign o_match = r_valid && (i_addr[ADDR_W-1:IDX_W] == r_base[ADDR_W-1:IDX_W]);

endmodule

// File: rtl/prog_mem_refill_ctrl.sv
// Ping-pong instruction bank controller: demand fills, sequential prefetch,
// bank switching and a single-outstanding req/ack path to program RAM.
module prog_mem_refill_ctrl
  import prog_mem_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              i_fetch_valid,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_hit,
  output logic              o_stall,
  output logic              o_rd_bank,
  output logic [IDX_W-1:0]  o_rd_idx,
  output logic              o_active_bank,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wr_en,
  output logic              o_wr_bank,
  output logic [IDX_W-1:0]  o_wr_idx,
  output logic [DATA_W-1:0] o_wr_data
);

  state_t            r_state, w_next_state;
  logic              r_active;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_wr_bank;
  logic [IDX_W-1:0]  r_wr_idx;

  logic [ADDR_W-1:0] w_base [2];
  logic [1:0]        w_valid, w_match;
  logic [1:0]        w_load, w_clr, w_set;
  logic [ADDR_W-1:0] w_load_base;

  logic              w_toggle, w_start_fill, w_fill_bank, w_advance, w_end_fill;
  logic [ADDR_W-1:0] w_fill_addr;

  line_tag u_tag0 (
    .clk(clk), .Reset(Reset), .i_load(w_load[0]), .i_clr(w_clr[0]), .i_set(w_set[0]),
    .i_base(w_load_base), .i_addr(i_fetch_addr),
    .o_base(w_base[0]), .o_valid(w_valid[0]), .o_match(w_match[0])
  );

  line_tag u_tag1 (
    .clk(clk), .Reset(Reset), .i_load(w_load[1]), .i_clr(w_clr[1]), .i_set(w_set[1]),
    .i_base(w_load_base), .i_addr(i_fetch_addr),
    .o_base(w_base[1]), .o_valid(w_valid[1]), .o_match(w_match[1])
  );

  // Views of the two banks relative to the switching pointer.
  logic              w_hit_act, w_hit_ina, w_act_valid, w_ina_valid;
  logic [ADDR_W-1:0] w_act_base, w_ina_base, w_miss_base, w_pf_base, w_swap_base;
  logic              w_ack, w_last, w_pf_line, w_miss, w_pf_done, w_seq_swap, w_swap, w_start_pf;

  assign w_hit_act   = r_active ? w_match[1] : w_match[0];
  assign w_hit_ina   = r_active ? w_match[0] : w_match[1];
  assign w_act_valid = r_active ? w_valid[1] : w_valid[0];
  assign w_ina_valid = r_active ? w_valid[0] : w_valid[1];
  assign w_act_base  = r_active ? w_base[1]  : w_base[0];
  assign w_ina_base  = r_active ? w_base[0]  : w_base[1];
  assign w_miss_base = line_base(i_fetch_addr);
  assign w_pf_base   = w_act_base + ADDR_W'(LINE_W);
  assign w_swap_base = w_ina_base + ADDR_W'(LINE_W);

  assign o_hit     = |w_match;
  assign o_stall   = i_fetch_valid && !o_hit;
  assign o_rd_bank = w_hit_act ? r_active : ~r_active;
  assign o_rd_idx  = i_fetch_addr[IDX_W-1:0];

  assign w_ack     = i_mem_ack && r_mem_req;
  assign w_last    = w_ack && (r_wr_idx == IDX_W'(LINE_W - 1));
  // A fetch into the line being prefetched waits for it instead of aborting it.
  assign w_pf_line = (r_state == ST_PREFETCH) &&
                     (i_fetch_addr[ADDR_W-1:IDX_W] == w_ina_base[ADDR_W-1:IDX_W]);
  assign w_miss    = i_fetch_valid && !o_hit && !w_pf_line;
  assign w_pf_done = (r_state == ST_PREFETCH) && w_last;
  // Completion counts as valid so a same-cycle line-end fetch still swaps.
  assign w_seq_swap = w_hit_act && (o_rd_idx == IDX_W'(LINE_W - 1)) &&
                      (w_ina_valid || w_pf_done) && (w_ina_base == w_pf_base);
  assign w_swap     = i_fetch_valid && (w_seq_swap || w_hit_ina);
  // Prefetch only once there is an active line to continue from.
  assign w_start_pf = w_act_valid && !w_ina_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_miss)                      w_next_state = ST_DEMAND;
        else if (w_swap || w_start_pf)   w_next_state = ST_PREFETCH;
      end
      ST_DEMAND: if (w_last) w_next_state = ST_IDLE;
      ST_PREFETCH: begin
        if (w_miss)      w_next_state = w_ack ? ST_DEMAND : ST_DRAIN;
        else if (w_swap) w_next_state = ST_PREFETCH;
        else if (w_last) w_next_state = ST_IDLE;
      end
      ST_DRAIN: if (w_ack) w_next_state = ST_DEMAND;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Per-state commands to the tags and the RAM request datapath.
  always_comb begin
    w_load       = '0;
    w_clr        = '0;
    w_set        = '0;
    w_load_base  = w_miss_base;
    w_toggle     = 1'b0;
    w_start_fill = 1'b0;
    w_fill_addr  = w_miss_base;
    w_fill_bank  = r_active;
    w_advance    = 1'b0;
    w_end_fill   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_load[r_active]  = 1'b1;
          w_clr[~r_active]  = 1'b1;
          w_start_fill      = 1'b1;
        end else if (w_swap) begin
          w_toggle          = 1'b1;
          w_load[r_active]  = 1'b1;
          w_load_base       = w_swap_base;
          w_start_fill      = 1'b1;
          w_fill_addr       = w_swap_base;
        end else if (w_start_pf) begin
          w_load[~r_active] = 1'b1;
          w_load_base       = w_pf_base;
          w_start_fill      = 1'b1;
          w_fill_addr       = w_pf_base;
          w_fill_bank       = ~r_active;
        end
      end
      ST_DEMAND: begin
        if (w_ack) begin
          w_advance = 1'b1;
          if (w_last) begin
            w_set[r_wr_bank] = 1'b1;
            w_end_fill       = 1'b1;
          end
        end
      end
      ST_PREFETCH: begin
        if (w_miss) begin
          // With an ack in hand the request can retarget at once; otherwise drain it.
          w_load[r_active] = 1'b1;
          w_clr[~r_active] = 1'b1;
          w_start_fill     = w_ack;
        end else if (w_swap) begin
          w_set[r_wr_bank] = 1'b1;
          w_toggle         = 1'b1;
          w_load[r_active] = 1'b1;
          w_load_base      = w_swap_base;
          w_start_fill     = 1'b1;
          w_fill_addr      = w_swap_base;
        end else if (w_ack) begin
          w_advance = 1'b1;
          if (w_last) begin
            w_set[r_wr_bank] = 1'b1;
            w_end_fill       = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Track the most recent miss so the demand fill targets it.
        if (i_fetch_valid) w_load[r_active] = 1'b1;
        if (w_ack) begin
          w_start_fill = 1'b1;
          w_fill_addr  = i_fetch_valid ? w_miss_base : w_act_base;
        end
      end
      default: ;
    endcase
  end

  // Registered RAM request, fill pointer and bank switch.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_active   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_wr_bank  <= 1'b0;
      r_wr_idx   <= '0;
    end else begin
      if (w_toggle) r_active <= ~r_active;
      if (w_start_fill) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_fill_addr;
        r_wr_bank  <= w_fill_bank;
        r_wr_idx   <= '0;
      end else if (w_advance) begin
        r_mem_addr <= r_mem_addr + 1'b1;
        r_wr_idx   <= r_wr_idx + 1'b1;
        if (w_end_fill) r_mem_req <= 1'b0;
      end
    end
  end

  assign o_active_bank = r_active;
  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_wr_en       = w_ack && (r_state != ST_DRAIN);
  assign o_wr_bank     = r_wr_bank;
  assign o_wr_idx      = r_wr_idx;
  assign o_wr_data     = i_mem_rdata;

endmodule

// File: tb/tb_prog_mem_refill_ctrl.sv
// Scoreboard bench for prog_mem_refill_ctrl: stimulus pushes expected RAM
// transfers and fetch responses; a negedge monitor pops and compares them.
module tb_prog_mem_refill_ctrl;
  import prog_mem_pkg::*;

  logic              clk = 1'b0;
  logic              Reset;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              hit, stall, rd_bank, active_bank, mem_req, mem_ack, wr_en, wr_bank;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, wr_data;

  always #5 clk = ~clk;

  prog_mem_refill_ctrl u_dut (
    .clk(clk), .Reset(Reset),
    .i_fetch_valid(fetch_valid), .i_fetch_addr(fetch_addr),
    .o_hit(hit), .o_stall(stall), .o_rd_bank(rd_bank), .o_rd_idx(rd_idx),
    .o_active_bank(active_bank),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_wr_en(wr_en), .o_wr_bank(wr_bank), .o_wr_idx(wr_idx), .o_wr_data(wr_data)
  );

  // RAM model: acks after ack_delay waiting cycles, data derived from the address.
  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;
  always @(posedge clk) begin
    if (!mem_req || mem_ack || Reset) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = 32'hCAFE_0000 ^ {22'd0, mem_addr};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              bank;
    logic [IDX_W-1:0]  idx;
  } ram_exp_t;

  typedef struct packed {
    logic stall;
    logic bank;
  } fetch_exp_t;

  ram_exp_t   ram_q[$];
  fetch_exp_t fetch_q[$];
  ram_exp_t   re;
  fetch_exp_t fe;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT completes a RAM transfer or a fetch is presented.
  logic              prev_req = 1'b0, prev_ack = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!Reset) begin
      if (prev_req && !prev_ack) begin
        check("mem_req_held", 32'(mem_req), 32'd1);
        check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
      end
      if (mem_req && mem_ack) begin
        if (ram_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL ram_extra_read: ack at addr 0x%0h with nothing expected", mem_addr);
        end else begin
          re = ram_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(re.addr));
          check("wr_en", 32'(wr_en), 32'(re.wr));
          if (re.wr) begin
            check("wr_bank", 32'(wr_bank), 32'(re.bank));
            check("wr_idx", 32'(wr_idx), 32'(re.idx));
            check("wr_data", wr_data, 32'hCAFE_0000 ^ {22'd0, re.addr});
          end
        end
      end else begin
        check("wr_en_without_ack", 32'(wr_en), 32'd0);
      end
      if (fetch_valid) begin
        if (fetch_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL fetch_unexpected: fetch of 0x%0h with nothing expected", fetch_addr);
        end else begin
          fe = fetch_q.pop_front();
          check("stall", 32'(stall), 32'(fe.stall));
          if (!fe.stall) check("rd_bank", 32'(rd_bank), 32'(fe.bank));
        end
      end
    end
    if (Reset) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input logic exp_stall, input logic exp_bank);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    fetch_q.push_back('{stall: exp_stall, bank: exp_bank});
    tick();
  endtask

  task automatic idle(input int n);
    fetch_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic exp_fill(input logic [ADDR_W-1:0] base, input int n, input logic wr, input logic bank);
    for (int i = 0; i < n; i++)
      ram_q.push_back('{addr: base + ADDR_W'(i), wr: wr, bank: bank, idx: IDX_W'(i)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_addr  = '0;
    repeat (3) tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_wr_bank", 32'(wr_bank), 32'd0);
    check("rst_wr_idx", 32'(wr_idx), 32'd0);
    check("rst_active_bank", 32'(active_bank), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    Reset = 1'b0;

    // Demand miss at 0x000: nine stall cycles, then prefetch of 0x008.
    exp_fill(10'h000, 8, 1'b1, 1'b0);
    exp_fill(10'h008, 8, 1'b1, 1'b1);
    repeat (9) fetch(10'h000, 1'b1, 1'b0);
    fetch(10'h000, 1'b0, 1'b0);
    check("pf_req_start", 32'(mem_req), 32'd1);
    check("pf_addr_start", 32'(mem_addr), 32'h008);
    idle(8);

    // Sequential run across the line end: swap after 0x007, then 0x00F completes and swaps again.
    exp_fill(10'h010, 8, 1'b1, 1'b0);
    exp_fill(10'h018, 8, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) fetch(10'(i), 1'b0, 1'b0);
    check("swap_to_bank1", 32'(active_bank), 32'd1);
    for (int i = 8; i < 16; i++) fetch(10'(i), 1'b0, 1'b1);
    check("swap_to_bank0", 32'(active_bank), 32'd0);
    idle(10);

    // Fetch into the line being prefetched after 3 words: stall until it completes, no re-read.
    exp_fill(10'h040, 8, 1'b1, 1'b0);
    exp_fill(10'h048, 8, 1'b1, 1'b1);
    exp_fill(10'h050, 8, 1'b1, 1'b0);
    repeat (9) fetch(10'h040, 1'b1, 1'b0);
    fetch(10'h040, 1'b0, 1'b0);
    fetch(10'h041, 1'b0, 1'b0);
    fetch(10'h042, 1'b0, 1'b0);
    fetch(10'h043, 1'b0, 1'b0);
    repeat (5) fetch(10'h048, 1'b1, 1'b0);
    fetch(10'h048, 1'b0, 1'b1);
    check("pf_line_switch", 32'(active_bank), 32'd1);
    idle(10);

    // Branch to 0x120 during a slow prefetch of 0x058: drained word not written, then demand fill.
    ack_delay = 4;
    ram_q.push_back('{addr: 10'h058, wr: 1'b0, bank: 1'b0, idx: '0});
    exp_fill(10'h120, 8, 1'b1, 1'b0);
    fetch(10'h04F, 1'b0, 1'b1);
    idle(1);
    repeat (44) fetch(10'h120, 1'b1, 1'b0);
    ack_delay = 0;
    exp_fill(10'h128, 8, 1'b1, 1'b1);
    fetch(10'h120, 1'b0, 1'b0);
    idle(10);

    // Line at 0x3F8: the prefetch address wraps to 0x000.
    exp_fill(10'h3F8, 8, 1'b1, 1'b0);
    exp_fill(10'h000, 8, 1'b1, 1'b1);
    repeat (9) fetch(10'h3FC, 1'b1, 1'b0);
    fetch(10'h3FC, 1'b0, 1'b0);
    check("wrap_req", 32'(mem_req), 32'd1);
    check("wrap_addr", 32'(mem_addr), 32'h000);
    idle(10);

    // Reset on the 5th ack of a demand fill, then a full miss again.
    exp_fill(10'h200, 4, 1'b1, 1'b0);
    repeat (5) fetch(10'h200, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    Reset       = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_fill_req", 32'(mem_req), 32'd0);
    fetch_addr = 10'h3F8;
    #1;
    check("rst_fill_hit_3f8", 32'(hit), 32'd0);
    fetch_addr = 10'h000;
    #1;
    check("rst_fill_hit_000", 32'(hit), 32'd0);
    check("rst_fill_active", 32'(active_bank), 32'd0);
    tick();
    exp_fill(10'h200, 8, 1'b1, 1'b0);
    exp_fill(10'h208, 8, 1'b1, 1'b1);
    repeat (9) fetch(10'h200, 1'b1, 1'b0);
    fetch(10'h200, 1'b0, 1'b0);
    idle(12);

    check("ram_q_left", 32'(ram_q.size()), 32'd0);
    check("fetch_q_left", 32'(fetch_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
